// File: rtl/dcc_seq_pkg.sv
// Shared state encoding and limits for the DCCA clock-enable sequencer.
package dcc_seq_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ON_SEQ  = 2'd1,
        ON      = 2'd2,
        OFF_SEQ = 2'd3
    } dcc_seq_state_t;

    localparam int MAX_STAGES = 8;

endpackage

// File: rtl/dcc_settle_counter.sv
// Settle-time down-counter: load, decrement to zero, synchronous clear.
module dcc_settle_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dcc_ce_sequencer.sv
// Orders the CE edges of a DCCA cascade: rising from stage 0 upward, falling from
// the last stage downward, with a settle interval after every edge.
module dcc_ce_sequencer
    import dcc_seq_pkg::*;
#(
    parameter int N_STAGES      = 2,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                clki,
    input  logic                rst,
    input  logic                en_req,
    input  logic                force_off,
    output logic [N_STAGES-1:0] ce,
    output logic                en_ack,
    output logic                busy,
    output logic [2:0]          stage,
    output dcc_seq_state_t      state_dbg
);

    if (N_STAGES < 1 || N_STAGES > MAX_STAGES) begin : g_bad_stages
        $error("dcc_ce_sequencer: N_STAGES must be 1..8");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("dcc_ce_sequencer: SETTLE_CYCLES must be >= 1");
    end

    localparam logic [N_STAGES-1:0] ONE    = N_STAGES'(1);
    localparam logic [2:0]          LAST   = 3'(N_STAGES - 1);
    localparam logic [CNT_W-1:0]    RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    dcc_seq_state_t      state_q, state_d;
    logic [2:0]          stage_q, stage_d;
    logic [N_STAGES-1:0] ce_q, ce_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                cnt_load, cnt_dec, cnt_clear, cnt_zero;
    logic [CNT_W-1:0]    cnt;

    dcc_settle_counter #(.CNT_W(CNT_W)) u_settle (
        .clk      (clki),
        .rst      (rst),
        .clear    (cnt_clear),
        .load     (cnt_load),
        .load_val (RELOAD),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clki) begin
        if (rst) begin
            state_q <= OFF;
            stage_q <= '0;
            ce_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            ce_q    <= ce_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Exactly one ce bit moves per transition, always at the thermometer boundary,
    // so ce stays thermometer-coded; a reversal reuses the current stage index.
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        ce_d      = ce_q;
        ack_d     = ack_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_clear = 1'b0;
        if (force_off) begin
            state_d   = OFF;
            stage_d   = '0;
            ce_d      = '0;
            ack_d     = 1'b0;
            cnt_clear = 1'b1;
        end else begin
            unique case (state_q)
                OFF: begin
                    if (en_req) begin
                        state_d  = ON_SEQ;
                        stage_d  = '0;
                        ce_d     = ce_q | ONE;
                        cnt_load = 1'b1;
                    end
                end
                ON_SEQ: begin
                    if (!en_req) begin
                        state_d  = OFF_SEQ;
                        ce_d     = ce_q & ~(ONE << stage_q);
                        cnt_load = 1'b1;
                    end else if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (stage_q < LAST) begin
                        stage_d  = stage_q + 3'd1;
                        ce_d     = ce_q | (ONE << (stage_q + 3'd1));
                        cnt_load = 1'b1;
                    end else begin
                        state_d = ON;
                        stage_d = '0;
                        ack_d   = 1'b1;
                    end
                end
                ON: begin
                    if (!en_req) begin
                        state_d  = OFF_SEQ;
                        stage_d  = LAST;
                        ce_d     = ce_q & ~(ONE << LAST);
                        cnt_load = 1'b1;
                    end
                end
                OFF_SEQ: begin
                    if (en_req) begin
                        state_d  = ON_SEQ;
                        ce_d     = ce_q | (ONE << stage_q);
                        ack_d    = 1'b0;
                        cnt_load = 1'b1;
                    end else if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (stage_q != 3'd0) begin
                        stage_d  = stage_q - 3'd1;
                        ce_d     = ce_q & ~(ONE << (stage_q - 3'd1));
                        cnt_load = 1'b1;
                    end else begin
                        state_d = OFF;
                        ack_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = OFF;
                end
            endcase
        end
        busy_d = (state_d == ON_SEQ) || (state_d == OFF_SEQ);
    end

    assign ce        = ce_q;
    assign en_ack    = ack_q;
    assign busy      = busy_q;
    assign stage     = stage_q;
    assign state_dbg = state_q;

endmodule
